bht_predictor: RTL
==================

# bht_predictor

Parametrised branch history table that replaces the single global 2-bit predictor. It gives a per-PC direction prediction (and, optionally, a branch target) to IF1 one cycle after IF0 presents the PC. EX trains it with the resolved outcome. Counter width, table depth and global-history folding (gshare) are configurable.

## Interface
Parameters:
- WORD, 32: PC/target width.
- ENTRIES, 64: number of counters; must be a power of 2, at least 4.
- CTR_BITS, 2: saturating counter width, 1 to 4.
- HIST_BITS, 0: global history length XORed into the index. 0 means plain PC indexing. Must be ≤ log2(ENTRIES).
- TAG_BITS, 8: target tag width; used only with BHT_BTB_EN.

Ports (IDX_W = log2(ENTRIES)):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  IF0 presents a PC this cycle.
- lookup_pc  in  WORD  PC to predict.
- stall  in  1  hold prediction outputs (ICache/DCache/load stall).
- flush  in  1  discard the pending prediction (EX redirect).
- pred_valid  out  1  prediction outputs are meaningful.
- pred_taken  out  1  predicted direction.
- pred_hit  out  1  target array hit.
- pred_target  out  WORD  predicted target.
- pred_idx  out  IDX_W  table index used; travels down the pipeline to EX.
- upd_valid  in  1  EX resolves a conditional branch this cycle.
- upd_idx  in  IDX_W  pred_idx carried with that branch.
- upd_pc  in  WORD  branch PC (tag source).
- upd_taken  in  1  resolved direction.
- upd_target  in  WORD  resolved target.

## Operation
- Index = lookup_pc[IDX_W+1:2] XOR {zero-extend(ghr)}. ghr is a HIST_BITS-bit shift register; it does not exist when HIST_BITS = 0.
- Counters reset to weakly-not-taken, 2^(CTR_BITS-1)-1. Prediction is taken when the counter MSB = 1.
- Update on upd_valid:
  - counter[upd_idx] increments, saturating at 2^CTR_BITS-1, if upd_taken.
  - Otherwise it decrements, saturating at 0.
  - ghr <= {ghr[HIST_BITS-2:0], upd_taken}. The history is non-speculative: only resolved branches shift it.
- Output register priority, evaluated each rising edge: rst > flush > stall > lookup.
  - flush: pred_valid <= 0. Other outputs don't care.
  - stall (no flush): all pred_* outputs hold.
  - Otherwise: pred_valid <= lookup_valid, and pred_taken/pred_idx/pred_hit/pred_target are loaded from the table.
- Lookup and update in the same cycle, same index: the lookup returns the pre-update counter value. No bypass.
- The update is applied regardless of stall and flush. Resolved branches are never dropped.
- Reset asserted mid-operation: every counter, ghr and every output clear immediately. pred_valid = 0, pred_taken = 0, pred_hit = 0, pred_target = 0, pred_idx = 0.

## Timing
- Lookup latency is 1 cycle: lookup at edge N gives outputs valid after edge N+1.
- An update at edge N is visible to a lookup sampled at edge N+1 or later.
- ghr change at edge N affects indices computed from cycle N+1.
- Table storage is flops, not BRAM, so reset clears it in 0 cycles and there is no init sweep.

## Configuration
- BHT_BTB_EN defined:
  - Adds an ENTRIES-deep direct-mapped target array. Each entry holds valid, tag = pc[TAG_BITS+IDX_W+1:IDX_W+2], and target.
  - The target array is indexed by pc[IDX_W+1:2], without the history XOR.
  - It is written on upd_valid with upd_taken = 1.
  - pred_hit = valid and tag match. pred_target = the stored target when pred_hit = 1, else 0.
  - Valid bits clear on reset.
- BHT_BTB_EN undefined: pred_hit and pred_target are tied to 0. IF1 keeps computing targets from the decoded offset.

## Structure
- Package bht_pkg holds:
  - the ctr_sat_inc and ctr_sat_dec functions;
  - the weak-NT reset constant function of CTR_BITS;
  - the IDX_W derivation.
- Sub-module bht_btb holds the tag/target array and is instantiated only under BHT_BTB_EN.
- The counter array and ghr stay in bht_predictor.

## Test plan
- Reset, then lookup PC 0x1C000000: pred_valid = 1, pred_taken = 0 next cycle (counter = 1 with CTR_BITS = 2).
- Saturation at idx 5: two taken updates then lookup gives taken. Then 3 more taken updates and 2 not-taken updates leave counter = 1, and a lookup gives not-taken.
- Same-cycle update and lookup on idx 5, counter = 1, upd_taken = 1: lookup returns not-taken; the next lookup returns taken.
- stall high for 3 cycles while lookup_pc changes: outputs frozen. flush asserted together with stall gives pred_valid = 0 next cycle.
- HIST_BITS = 2: after updates T,T (ghr = 2'b11), lookup PC 0x14 (PC index 5) reports pred_idx = 6.
- BHT_BTB_EN: taken update at PC 0x20 with target 0x100 gives pred_hit = 1 and pred_target = 0x100 on the next lookup of 0x20. Lookup of an aliasing PC with a different tag gives pred_hit = 0.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared helpers for the branch history table: counter arithmetic, reset value, index width.
package bht_pkg;

    localparam int unsigned CTR_MAX_W = 4;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    function automatic int unsigned idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic ctr_t ctr_max(input int unsigned bits);
        return ctr_t'((1 << bits) - 1);
    endfunction

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic ctr_t ctr_weak_nt(input int unsigned bits);
        return ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    function automatic ctr_t ctr_sat_inc(input ctr_t v, input int unsigned bits);
        return (v == ctr_max(bits)) ? v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t ctr_sat_dec(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

endpackage

// File: rtl/bht_btb.sv
// Direct-mapped branch target array; indexed by raw PC bits, written by taken branches.
module bht_btb #(
    parameter int unsigned WORD     = 32,
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned TAG_BITS = 8,
    parameter int unsigned IDX_W    = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] i_lookup_pc,
    input  logic            i_upd_valid,
    input  logic [WORD-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [WORD-1:0] i_upd_target,
    output logic            o_hit,
    output logic [WORD-1:0] o_target
);

    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = TAG_BITS + IDX_W + 1;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [WORD-1:0]     r_target [ENTRIES];

    logic [IDX_W-1:0]    w_rd_idx;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [TAG_BITS-1:0] w_rd_tag;
    logic                w_wr_en;
    logic                w_unused_pc;

    assign w_rd_idx    = i_lookup_pc[IDX_W+1:2];
    assign w_wr_idx    = i_upd_pc[IDX_W+1:2];
    assign w_rd_tag    = i_lookup_pc[TAG_HI:TAG_LO];
    assign w_wr_en     = i_upd_valid && i_upd_taken;
    assign w_unused_pc = ^{i_lookup_pc, i_upd_pc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag and target payload need no reset: they are qualified by r_valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag[w_wr_idx]    <= i_upd_pc[TAG_HI:TAG_LO];
            r_target[w_wr_idx] <= i_upd_target;
        end
    end

    always_comb begin
        o_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
        o_target = o_hit ? r_target[w_rd_idx] : '0;
    end

endmodule

// File: rtl/bht_predictor.sv
// Per-PC branch direction predictor with optional gshare history.
// Define BHT_BTB_EN to add a tagged branch target array.
module bht_predictor
    import bht_pkg::*;
#(
    parameter int unsigned WORD      = 32,
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned HIST_BITS = 0,
    parameter int unsigned TAG_BITS  = 8,
    localparam int unsigned IDX_W    = idx_w(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [WORD-1:0]  lookup_pc,
    input  logic             stall,
    input  logic             flush,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic             pred_hit,
    output logic [WORD-1:0]  pred_target,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [WORD-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [WORD-1:0]  upd_target
);

    logic [CTR_BITS-1:0] r_ctr [ENTRIES];

    logic [IDX_W-1:0]    w_hist_idx;
    logic [IDX_W-1:0]    w_lookup_idx;
    logic [CTR_BITS-1:0] w_lookup_ctr;
    logic [CTR_BITS-1:0] w_upd_ctr;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic                w_btb_hit;
    logic [WORD-1:0]     w_btb_target;

    logic                r_pred_valid;
    logic                r_pred_taken;
    logic                r_pred_hit;
    logic [WORD-1:0]     r_pred_target;
    logic [IDX_W-1:0]    r_pred_idx;

    generate
        if (HIST_BITS == 0) begin : g_no_hist
            assign w_hist_idx = '0;
        end else begin : g_hist
            logic [HIST_BITS-1:0] r_ghr;

            // Non-speculative: only resolved branches shift the history.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_ghr <= '0;
                end else if (upd_valid) begin
                    r_ghr <= HIST_BITS'({r_ghr, upd_taken});
                end
            end

            assign w_hist_idx = IDX_W'(r_ghr);
        end
    endgenerate

    assign w_lookup_idx = lookup_pc[IDX_W+1:2] ^ w_hist_idx;
    assign w_lookup_ctr = r_ctr[w_lookup_idx];
    assign w_upd_ctr    = r_ctr[upd_idx];
    assign w_ctr_next   = upd_taken
                        ? CTR_BITS'(ctr_sat_inc(ctr_t'(w_upd_ctr), CTR_BITS))
                        : CTR_BITS'(ctr_sat_dec(ctr_t'(w_upd_ctr)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_BITS'(ctr_weak_nt(CTR_BITS));
            end
        end else if (upd_valid) begin
            r_ctr[upd_idx] <= w_ctr_next;
        end
    end

`ifdef BHT_BTB_EN
    bht_btb #(
        .WORD     (WORD),
        .ENTRIES  (ENTRIES),
        .TAG_BITS (TAG_BITS),
        .IDX_W    (IDX_W)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .i_lookup_pc  (lookup_pc),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target),
        .o_hit        (w_btb_hit),
        .o_target     (w_btb_target)
    );
`else
    logic w_unused_btb;

    assign w_btb_hit    = 1'b0;
    assign w_btb_target = '0;
    assign w_unused_btb = ^{lookup_pc, upd_pc, upd_target};
`endif

    // Flush only kills valid; the payload is don't-care until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_hit    <= 1'b0;
            r_pred_target <= '0;
            r_pred_idx    <= '0;
        end else if (flush) begin
            r_pred_valid  <= 1'b0;
        end else if (!stall) begin
            r_pred_valid  <= lookup_valid;
            r_pred_taken  <= w_lookup_ctr[CTR_BITS-1];
            r_pred_hit    <= w_btb_hit;
            r_pred_target <= w_btb_target;
            r_pred_idx    <= w_lookup_idx;
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign pred_hit    = r_pred_hit;
    assign pred_target = r_pred_target;
    assign pred_idx    = r_pred_idx;

endmodule
